mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- RV32 memory-access pipeline stage, directly upstream of the writeback stage.
- Takes execute-stage results and performs load/store transactions on a valid/ack data-memory port.
- Generates byte strobes and lane-replicated store data; right-aligns load data.
- Presents registered ALU result, load data, rd, f3 and enables to writeback every cycle; stalls execute while a transaction is outstanding.

Parameters:
- TIMEOUT, 255, max cycles waiting for dm_ack before aborting with bus error; 0 disables the timeout.
- ADDR_W, 32, data-memory address width; dm_addr = low ADDR_W bits of ex_alu_out.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  execute presents an instruction this cycle
ex_alu_out  in  32  ALU result / effective address
ex_rs2  in  32  store data source
ex_rd  in  5  destination register
ex_reg_w_en  in  1  ALU-result register write
ex_f3  in  3  funct3 (width/sign)
ex_d_r_en  in  1  load
ex_d_w_en  in  1  store
stall  out  1  execute must hold its outputs
dm_req  out  1  memory request valid
dm_we  out  1  1 = store
dm_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
dm_be  out  4  byte strobes
dm_wdata  out  32  store data
dm_rdata  in  32  load data, valid with dm_ack
dm_ack  in  1  transaction complete
alu_rd  out  5  to writeback
ALU_out  out  32  to writeback
d_out  out  32  right-aligned load data
alu_reg_w_en  out  1  to writeback
f3  out  3  to writeback
d_r_en  out  1  to writeback
d_w_en  out  1  to writeback
misalign  out  1  one-cycle pulse: misaligned/illegal access dropped
bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset: every output register, including dm_req, is 0; state IDLE; timeout counter 0. A reset during BUSY drops dm_req on the next edge, and any late dm_ack is ignored.
- FSM states: IDLE, BUSY.
- IDLE, non-memory op (ex_valid, neither d_r_en nor d_w_en):
  - Next edge registers ALU_out, alu_rd, alu_reg_w_en and f3.
  - d_out = 0.
  - 1-cycle latency.
- IDLE, legal memory op:
  - Capture address, f3, rd, strobes and wdata; go to BUSY.
  - Writeback outputs that edge are a bubble: all enables 0, misalign 0, bus_err 0.
- IDLE, ex_valid = 0: output a bubble.
- BUSY:
  - dm_req = 1; dm_addr, dm_we, dm_be and dm_wdata held stable.
  - stall = 1; ex_* inputs are ignored.
  - Each cycle without ack outputs a bubble.
- BUSY with dm_ack:
  - Next edge registers the result, load/store enables and alu_reg_w_en.
  - Next edge also sets dm_req = 0, returns to IDLE and clears the counter.
  - stall deasserts the cycle after the ack, and the held instruction is accepted then.
  - Minimum load-to-writeback latency: accept at T, req at T+1, ack at T+1, outputs valid at T+2.
- Timeout:
  - Counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT (TIMEOUT ≠ 0), return to IDLE and pulse bus_err with bubble enables.
  - dm_ack and timeout in the same cycle: ack wins.
- stall = (state == BUSY). No combinational path from dm_ack to stall.
- Store lanes, with off = ex_alu_out[1:0]:
  - SB (f3 000): be = 0001 << off; wdata = rs2[7:0] replicated ×4.
  - SH (f3 001): be = 0011 << off; wdata = rs2[15:0] replicated ×2.
  - SW (f3 010): be = 1111; wdata = rs2.
- Loads:
  - dm_be = 1111.
  - d_out = dm_rdata >> (8·off), upper bits zero.
  - Width masking and sign handling are done in writeback.
- Illegal or misaligned:
  - Half access with off[0] = 1.
  - Word access with off ≠ 0.
  - Load f3 ∈ {011, 110, 111}.
  - Store f3 > 010.
  - d_r_en and d_w_en both set.
  - Response: no dm_req; next edge outputs a bubble with misalign = 1; stay in IDLE.

Decomposition:
- Shared package rv32_pkg:
  - F3_B / F3_H / F3_W / F3_BU / F3_HU constants.
  - lsu_state_t enum {IDLE, BUSY}.
  - Bubble value defaults.
- One combinational sub-module lsu_align:
  - Inputs: f3, off, rs2, rdata.
  - Outputs: be, wdata, load-extracted data, misalign flag.
  - The FSM and registers stay in mem_access_stage.

Test Plan:
- ADD result 0x0000_1234 to rd 5, no memory op -> next cycle ALU_out = 0x1234, alu_rd = 5, alu_reg_w_en = 1, stall never high.
- SB, addr 0x1003, rs2 0xAABBCCDD, ack after 3 cycles -> dm_addr = 0x1000, be = 1000, wdata = 0xDDDDDDDD, stall high for 3 cycles, then d_w_en = 1 for one cycle.
- LHU, addr 0x2002, dm_rdata 0x8001_7F00, immediate ack -> d_out = 0x0000_8001, d_r_en = 1, f3 = 101, output at T+2.
- LW, addr 0x3001 -> no dm_req, misalign pulse, all enables 0; following instruction accepted the next cycle.
- TIMEOUT = 4, load with no ack -> bus_err pulses after 4 BUSY cycles, state IDLE, dm_req low; rst asserted mid-BUSY -> next cycle all outputs 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 width codes, LSU state type, writeback bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   F3_*        funct3 encodings for loads/stores
//   lsu_state_t memory-stage FSM state
//   wb_t        registered writeback bundle, WB_BUBBLE is its all-zero bubble value
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        reg_w_en;
        logic        d_r_en;
        logic        d_w_en;
        logic        misalign;
        logic        bus_err;
    } wb_t;

    // A bubble carries no data and no enables.
    localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32 loads/stores: store strobes/data, load right-align, legality.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   f3, off      funct3 and byte offset (address bits [1:0])
//   ld, st       access is a load / a store
//   rs2, rdata   store source and raw memory read data
//   be, wdata    byte strobes and lane-replicated store data
//   ld_data      read data shifted down to byte 0, upper bits zero
//   misalign     access is misaligned or has an illegal encoding
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  off,
    input  logic        ld,
    input  logic        st,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    always_comb begin
        be    = 4'b0000;
        wdata = rs2;
        if (ld) begin
            // Loads always fetch the whole word; narrowing happens in writeback.
            be = 4'b1111;
        end else begin
            case (f3)
                F3_B: begin
                    be    = 4'b0001 << off;
                    wdata = {4{rs2[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << off;
                    wdata = {2{rs2[15:0]}};
                end
                F3_W:    be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    always_comb begin
        misalign = 1'b0;
        if (ld && st) begin
            misalign = 1'b1;
        end else if (ld) begin
            case (f3)
                F3_B, F3_BU: misalign = 1'b0;
                F3_H, F3_HU: misalign = off[0];
                F3_W:        misalign = (off != 2'b00);
                default:     misalign = 1'b1;
            endcase
        end else if (st) begin
            case (f3)
                F3_B:    misalign = 1'b0;
                F3_H:    misalign = off[0];
                F3_W:    misalign = (off != 2'b00);
                default: misalign = 1'b1;
            endcase
        end
    end

    assign ld_data = rdata >> {off, 3'b000};

endmodule

// File: rtl/mem_access_stage.sv
// RV32 memory-access stage: issues loads/stores on a valid/ack port, registers results for writeback.
// Latency: 1 cycle for non-memory ops; memory ops complete the edge after dm_ack (min 2 cycles).
// Backpressure: stall is high for every cycle a transaction is outstanding (registered, no ack path).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ex_*                             instruction from execute (sampled only while stall is low)
//   stall                            execute must hold its outputs
//   dm_req/we/addr/be/wdata          data-memory request, held stable while outstanding
//   dm_rdata, dm_ack                 data-memory response
//   ALU_out, d_out, alu_rd, f3,
//   alu_reg_w_en, d_r_en, d_w_en     registered writeback bundle
//   misalign, bus_err                one-cycle fault pulses
module mem_access_stage
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_w_en,
    input  logic [2:0]        ex_f3,
    input  logic              ex_d_r_en,
    input  logic              ex_d_w_en,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic [4:0]        alu_rd,
    output logic [31:0]       ALU_out,
    output logic [31:0]       d_out,
    output logic              alu_reg_w_en,
    output logic [2:0]        f3,
    output logic              d_r_en,
    output logic              d_w_en,
    output logic              misalign,
    output logic              bus_err
);

    // Counter value on the last BUSY cycle before the abort fires.
    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    lsu_state_t  state;
    logic [31:0] tmo_cnt;
    wb_t         wb_q;

    // Instruction captured on acceptance of a memory op.
    logic [31:0] alu_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic        st_q;
    logic        rw_q;

    logic        busy;
    logic        is_mem;
    logic        tmo_hit;

    logic [2:0]  a_f3;
    logic [1:0]  a_off;
    logic        a_ld;
    logic        a_st;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] a_ld_data;
    logic        a_misalign;

    assign busy    = (state == BUSY);
    assign is_mem  = ex_d_r_en | ex_d_w_en;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // While BUSY the aligner only has to right-align read data, so it is fed
    // the captured instruction; in IDLE it sees the incoming one.
    assign a_f3  = busy ? f3_q  : ex_f3;
    assign a_off = busy ? off_q : ex_alu_out[1:0];
    assign a_ld  = busy ? ld_q  : ex_d_r_en;
    assign a_st  = busy ? st_q  : ex_d_w_en;

    lsu_align u_align (
        .f3       (a_f3),
        .off      (a_off),
        .ld       (a_ld),
        .st       (a_st),
        .rs2      (ex_rs2),
        .rdata    (dm_rdata),
        .be       (a_be),
        .wdata    (a_wdata),
        .ld_data  (a_ld_data),
        .misalign (a_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            wb_q     <= WB_BUBBLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_wdata <= '0;
            alu_q    <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            off_q    <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            // Every edge produces a bubble unless something completes.
            wb_q <= WB_BUBBLE;
            if (!busy) begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_q.alu      <= ex_alu_out;
                        wb_q.rd       <= ex_rd;
                        wb_q.reg_w_en <= ex_reg_w_en;
                        wb_q.f3       <= ex_f3;
                    end else if (a_misalign) begin
                        // Dropped without touching the bus.
                        wb_q.misalign <= 1'b1;
                    end else begin
                        alu_q    <= ex_alu_out;
                        rd_q     <= ex_rd;
                        f3_q     <= ex_f3;
                        off_q    <= ex_alu_out[1:0];
                        ld_q     <= ex_d_r_en;
                        st_q     <= ex_d_w_en;
                        rw_q     <= ex_reg_w_en;
                        dm_req   <= 1'b1;
                        dm_we    <= ex_d_w_en;
                        dm_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
                        dm_be    <= a_be;
                        dm_wdata <= a_wdata;
                        tmo_cnt  <= '0;
                        state    <= BUSY;
                    end
                end
            end else begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (dm_ack) begin
                    wb_q.alu      <= alu_q;
                    wb_q.d        <= ld_q ? a_ld_data : 32'd0;
                    wb_q.rd       <= rd_q;
                    wb_q.f3       <= f3_q;
                    wb_q.reg_w_en <= rw_q;
                    wb_q.d_r_en   <= ld_q;
                    wb_q.d_w_en   <= st_q;
                    dm_req        <= 1'b0;
                    tmo_cnt       <= '0;
                    state         <= IDLE;
                end else if (tmo_hit) begin
                    wb_q.bus_err <= 1'b1;
                    dm_req       <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
        end
    end

    assign stall        = busy;
    assign ALU_out      = wb_q.alu;
    assign d_out        = wb_q.d;
    assign alu_rd       = wb_q.rd;
    assign f3           = wb_q.f3;
    assign alu_reg_w_en = wb_q.reg_w_en;
    assign d_r_en       = wb_q.d_r_en;
    assign d_w_en       = wb_q.d_w_en;
    assign misalign     = wb_q.misalign;
    assign bus_err      = wb_q.bus_err;

endmodule
